// File: rtl/rst_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// rst_seq_ctrl_if
//
// Purpose: bundles the request/status signals of the staged reset
// distributor so that the controller and its consumers share one port.
//
// Signals:
//   soft_rst_req   requester -> controller, level request for a staged re-reset
//   rst_n_out      controller -> blocks, per-stage active-low resets
//   seq_done       controller -> requester, all stages released, in RUN
//   soft_rst_busy  controller -> requester, sequence in progress
//   rst_ack_in     blocks -> controller, per-stage ready level
//                  (present only when RSTSEQ_ACK_EN is defined)
//
// Modports:
//   master  requester / reset consumers side
//   slave   the rst_seq_ctrl controller
//
// Build option: RSTSEQ_ACK_EN adds the rst_ack_in handshake.
// ---------------------------------------------------------------------------
interface rst_seq_ctrl_if #(
  parameter int NUM_STAGES = 4
);

  logic                  soft_rst_req;
  logic [NUM_STAGES-1:0] rst_n_out;
  logic                  seq_done;
  logic                  soft_rst_busy;
`ifdef RSTSEQ_ACK_EN
  logic [NUM_STAGES-1:0] rst_ack_in;
`endif

`ifdef RSTSEQ_ACK_EN
  modport master (
    output soft_rst_req,
    output rst_ack_in,
    input  rst_n_out,
    input  seq_done,
    input  soft_rst_busy
  );

  modport slave (
    input  soft_rst_req,
    input  rst_ack_in,
    output rst_n_out,
    output seq_done,
    output soft_rst_busy
  );
`else
  modport master (
    output soft_rst_req,
    input  rst_n_out,
    input  seq_done,
    input  soft_rst_busy
  );

  modport slave (
    input  soft_rst_req,
    output rst_n_out,
    output seq_done,
    output soft_rst_busy
  );
`endif

endinterface

// File: rtl/rst_seq_ctrl.sv
// ---------------------------------------------------------------------------
// rst_seq_ctrl
//
// Purpose: staged reset distributor. Takes the synchronised system reset
// and produces NUM_STAGES active-low block resets, released in ascending
// order after power-up and, on a soft-reset request, asserted in
// descending order, held, then released again.
//
// Ports:
//   clk_sys    system clock
//   rst_n_sys  asynchronous active-low reset
//   bus        rst_seq_ctrl_if.slave: soft_rst_req in, rst_n_out /
//              seq_done / soft_rst_busy out (all registered),
//              rst_ack_in in when RSTSEQ_ACK_EN is defined
//
// Parameters:
//   NUM_STAGES  number of staged resets (2..8)
//   STAGE_DLY   clk_sys cycles between consecutive stage edges (>= 1)
//   HOLD_CYC    cycles all stages stay asserted before release (>= 1)
//
// Build option: RSTSEQ_ACK_EN gates each release on the ready level of the
// previously released stage, and RUN entry on the last stage's ready.
//
// state   | meaning
// --------+---------------------------------------------------------------
// HOLD    | all stages asserted, counting HOLD_CYC before releasing stage 0
// RELEASE | releasing stages 1..N-1, one every STAGE_DLY cycles
// RUN     | all stages released, waiting for a soft-reset request
// ASSERT  | asserting stages N-2..0, one every STAGE_DLY cycles
// ---------------------------------------------------------------------------
module rst_seq_ctrl #(
  parameter int NUM_STAGES = 4,
  parameter int STAGE_DLY  = 16,
  parameter int HOLD_CYC   = 8
) (
  input logic           clk_sys,
  input logic           rst_n_sys,
  rst_seq_ctrl_if.slave bus
);

  localparam int MAX_DLY = (STAGE_DLY > HOLD_CYC) ? STAGE_DLY : HOLD_CYC;
  // A one-cycle delay still needs a (constant zero) counter bit.
  localparam int CNT_W   = (MAX_DLY > 1) ? $clog2(MAX_DLY) : 1;
`ifdef RSTSEQ_ACK_EN
  // One extra index value marks "last stage released, waiting for its ack".
  localparam int IDX_W   = $clog2(NUM_STAGES + 1);
`else
  localparam int IDX_W   = $clog2(NUM_STAGES);
`endif

  localparam logic [CNT_W-1:0]      STAGE_TC  = CNT_W'(STAGE_DLY - 1);
  localparam logic [CNT_W-1:0]      HOLD_TC   = CNT_W'(HOLD_CYC - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_STAGES - 1);
  localparam logic [IDX_W-1:0]      IDX_PEN   = IDX_W'(NUM_STAGES - 2);
  localparam logic [NUM_STAGES-1:0] STAGE_ONE = NUM_STAGES'(1);
`ifdef RSTSEQ_ACK_EN
  localparam logic [IDX_W-1:0]      IDX_WAIT  = IDX_W'(NUM_STAGES);
`endif

  typedef enum logic [1:0] {
    S_HOLD,
    S_RELEASE,
    S_RUN,
    S_ASSERT
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_STAGES-1:0] rst_n_q, rst_n_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;

  logic [NUM_STAGES-1:0] idx_mask;
  assign idx_mask = STAGE_ONE << idx_q;

`ifdef RSTSEQ_ACK_EN
  // Ready level of the stage released just before the current index.
  logic ack_prev;
  logic ack_last;
  assign ack_prev = |(bus.rst_ack_in & (STAGE_ONE << (idx_q - 1'b1)));
  assign ack_last = bus.rst_ack_in[NUM_STAGES-1];
`endif

  always_ff @(posedge clk_sys or negedge rst_n_sys) begin
    if (!rst_n_sys) begin
      state_q <= S_HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_n_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_n_q <= rst_n_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_n_d = rst_n_q;
    done_d  = done_q;
    busy_d  = busy_q;

    unique case (state_q)
      S_HOLD: begin
        if (cnt_q == HOLD_TC) begin
          rst_n_d = rst_n_q | STAGE_ONE;
          cnt_d   = '0;
          idx_d   = IDX_W'(1);
          state_d = S_RELEASE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_RELEASE: begin
`ifdef RSTSEQ_ACK_EN
        if (idx_q == IDX_WAIT) begin
          if (ack_last) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_RUN;
          end
        end else if (cnt_q == STAGE_TC) begin
          // Counter saturates at terminal count until the previous stage is ready.
          if (ack_prev) begin
            rst_n_d = rst_n_q | idx_mask;
            cnt_d   = '0;
            if (idx_q == IDX_LAST) begin
              if (ack_last) begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_RUN;
              end else begin
                idx_d = IDX_WAIT;
              end
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`else
        if (cnt_q == STAGE_TC) begin
          rst_n_d = rst_n_q | idx_mask;
          cnt_d   = '0;
          if (idx_q == IDX_LAST) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_RUN;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end

      S_RUN: begin
        if (bus.soft_rst_req) begin
          rst_n_d = rst_n_q & ~(STAGE_ONE << (NUM_STAGES - 1));
          done_d  = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
          idx_d   = IDX_PEN;
          state_d = S_ASSERT;
        end
      end

      S_ASSERT: begin
        if (cnt_q == STAGE_TC) begin
          rst_n_d = rst_n_q & ~idx_mask;
          cnt_d   = '0;
          if (idx_q == '0) begin
            state_d = S_HOLD;
          end else begin
            idx_d = idx_q - 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = S_HOLD;
      end
    endcase
  end

  assign bus.rst_n_out     = rst_n_q;
  assign bus.seq_done      = done_q;
  assign bus.soft_rst_busy = busy_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rst_seq_ctrl
//
// Self-checking bench for rst_seq_ctrl. The main instance runs default
// parameters; expected output changes (edge number + value) come from a
// timeline model and are queued, and a negedge monitor pops and compares
// them whenever the outputs change. A second instance with the minimum
// parameter set is checked edge by edge against a fixed table.
// ---------------------------------------------------------------------------
module tb_rst_seq_ctrl;

  localparam int NS = 4;
  localparam int SD = 16;
  localparam int HC = 8;

  typedef struct {
    int            edge_no;
    logic [NS-1:0] val;
    logic          done;
    logic          busy;
  } ev_t;

  logic clk_sys = 1'b0;
  logic rst_n_sys;
  logic rst_n2;

  always #5 clk_sys = ~clk_sys;

  rst_seq_ctrl_if #(.NUM_STAGES(NS)) bus ();
  rst_seq_ctrl_if #(.NUM_STAGES(2))  bus2 ();

  rst_seq_ctrl #(.NUM_STAGES(NS), .STAGE_DLY(SD), .HOLD_CYC(HC)) u_dut (
    .clk_sys   (clk_sys),
    .rst_n_sys (rst_n_sys),
    .bus       (bus)
  );

  rst_seq_ctrl #(.NUM_STAGES(2), .STAGE_DLY(1), .HOLD_CYC(1)) u_dut2 (
    .clk_sys   (clk_sys),
    .rst_n_sys (rst_n2),
    .bus       (bus2)
  );

`ifdef RSTSEQ_ACK_EN
  initial begin
    bus.rst_ack_in  = '1;
    bus2.rst_ack_in = '1;
  end
`endif

  int   checks = 0;
  int   errors = 0;
  int   edge_cnt;
  int   run_edge;
  ev_t  exp_q[$];

  localparam logic [NS+1:0] RST_OBS = {{NS{1'b0}}, 1'b0, 1'b1};
  logic [NS+1:0] prev_obs = RST_OBS;

  always @(posedge clk_sys or negedge rst_n_sys) begin
    if (!rst_n_sys) edge_cnt <= 0;
    else            edge_cnt <= edge_cnt + 1;
  end

  // ---------------- reference timeline model ----------------
  function automatic logic [NS-1:0] low_ones(int n);
    logic [NS:0] v;
    v = ((NS+1)'(1) << n) - (NS+1)'(1);
    return v[NS-1:0];
  endfunction

  task automatic push_ev(int e, logic [NS-1:0] v, logic d, logic b);
    ev_t ev;
    ev.edge_no = e; ev.val = v; ev.done = d; ev.busy = b;
    exp_q.push_back(ev);
  endtask

  // Stage k released at base + k*SD; RUN entered with the last one.
  task automatic push_release(int base);
    for (int k = 0; k < NS; k++)
      push_ev(base + k*SD, low_ones(k+1), (k == NS-1), (k != NS-1));
    run_edge = base + (NS-1)*SD;
  endtask

  // Request honoured at edge t: stage k asserted at t + (NS-1-k)*SD.
  task automatic push_cycle(int t);
    for (int k = NS-1; k >= 0; k--)
      push_ev(t + (NS-1-k)*SD, low_ones(k), 1'b0, 1'b1);
    push_release(t + (NS-1)*SD + HC);
  endtask

  // Request level sampled high at edges first..last; only edges after RUN
  // entry start a cycle, everything else is dropped.
  task automatic model_req(int first, int last);
    for (int j = first; j <= last; j++)
      if (j > run_edge) push_cycle(j);
  endtask

  // ---------------- monitor ----------------
  task automatic monitor_step();
    logic [NS+1:0] cur;
    logic [NS:0]   ext;
    ev_t           ev;
    cur = {bus.rst_n_out, bus.seq_done, bus.soft_rst_busy};
    ext = {1'b0, bus.rst_n_out};
    checks++;
    if (((ext + (NS+1)'(1)) & ext) != '0 || (bus2.rst_n_out[1] && !bus2.rst_n_out[0])) begin
      errors++;
      $display("FAIL ordering: out %b out2 %b at edge %0d, required contiguous from bit 0",
               bus.rst_n_out, bus2.rst_n_out, edge_cnt);
    end
    if (!rst_n_sys) begin
      prev_obs = RST_OBS;
    end else if (cur != prev_obs) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change: edge %0d out %b done %b busy %b, required no change",
                 edge_cnt, bus.rst_n_out, bus.seq_done, bus.soft_rst_busy);
      end else begin
        ev = exp_q.pop_front();
        if (edge_cnt != ev.edge_no || cur != {ev.val, ev.done, ev.busy}) begin
          errors++;
          $display("FAIL event: edge %0d out %b done %b busy %b, required edge %0d out %b done %b busy %b",
                   edge_cnt, bus.rst_n_out, bus.seq_done, bus.soft_rst_busy,
                   ev.edge_no, ev.val, ev.done, ev.busy);
        end
      end
      prev_obs = cur;
    end else if (exp_q.size() > 0 && exp_q[0].edge_no < edge_cnt) begin
      checks++;
      errors++;
      ev = exp_q.pop_front();
      $display("FAIL missed_event: edge %0d out %b, required out %b at edge %0d",
               edge_cnt, bus.rst_n_out, ev.val, ev.edge_no);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk_sys);
      monitor_step();
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step_to(int e);
    int n;
    n = 0;
    while (edge_cnt < e && n < 5000) begin
      @(posedge clk_sys);
      #1;
      n++;
    end
    #1;
    if (edge_cnt < e) begin
      checks++;
      errors++;
      $display("FAIL timeout: edge %0d, required edge %0d", edge_cnt, e);
    end
  endtask

  task automatic check_reset_now(string tag);
    checks++;
    if ({bus.rst_n_out, bus.seq_done, bus.soft_rst_busy} != RST_OBS) begin
      errors++;
      $display("FAIL %s: out %b done %b busy %b, required out 0 done 0 busy 1",
               tag, bus.rst_n_out, bus.seq_done, bus.soft_rst_busy);
    end
  endtask

  task automatic release_main();
    @(posedge clk_sys);
    #3;
    rst_n_sys = 1'b1;
    push_release(HC);
  endtask

  task automatic mid_reset(int at_edge);
    step_to(at_edge);
    rst_n_sys = 1'b0;
    bus.soft_rst_req = 1'b0;
    #1;
    check_reset_now("async_reset");
    exp_q.delete();
    run_edge = 0;
    repeat (2) @(posedge clk_sys);
    release_main();
    step_to(run_edge + 3);
  endtask

  // {rst_n_out[1:0], seq_done, soft_rst_busy} after edges 1..14
  logic [3:0] exp2 [1:14];

  initial begin
    int start, len, gap;
    rst_n_sys = 1'b0;
    rst_n2    = 1'b0;
    bus.soft_rst_req  = 1'b0;
    bus2.soft_rst_req = 1'b0;
    run_edge = 0;
    for (int e = 1; e <= 14; e++) exp2[e] = 4'b1110;
    exp2[1]  = 4'b0101;
    exp2[10] = 4'b0101;
    exp2[11] = 4'b0001;
    exp2[12] = 4'b0101;

    #12;
    check_reset_now("reset_state");
    checks++;
    if ({bus2.rst_n_out, bus2.seq_done, bus2.soft_rst_busy} != 4'b0001) begin
      errors++;
      $display("FAIL reset_state2: got %b required 0001",
               {bus2.rst_n_out, bus2.seq_done, bus2.soft_rst_busy});
    end

    // Minimum parameter corner on the second instance.
    @(posedge clk_sys);
    #3;
    rst_n2 = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      if (e == 10) bus2.soft_rst_req = 1'b1;
      @(posedge clk_sys);
      #1;
      if (e == 10) bus2.soft_rst_req = 1'b0;
      checks++;
      if ({bus2.rst_n_out, bus2.seq_done, bus2.soft_rst_busy} != exp2[e]) begin
        errors++;
        $display("FAIL corner edge %0d: got %b required %b", e,
                 {bus2.rst_n_out, bus2.seq_done, bus2.soft_rst_busy}, exp2[e]);
      end
    end

    // Power-up on the main instance.
    release_main();

    // One-cycle request at edge 100.
    step_to(99);
    bus.soft_rst_req = 1'b1;
    model_req(100, 100);
    step_to(100);
    bus.soft_rst_req = 1'b0;

    // Held from 120 (ignored while busy) until one edge after RUN at 204.
    step_to(119);
    bus.soft_rst_req = 1'b1;
    model_req(120, 205);
    step_to(205);
    bus.soft_rst_req = 1'b0;

    // Randomised requests of random length and spacing.
    for (int i = 0; i < 8; i++) begin
      gap   = int'($urandom_range(1, 120));
      len   = int'($urandom_range(1, 40));
      start = edge_cnt + gap;
      step_to(start - 1);
      bus.soft_rst_req = 1'b1;
      model_req(start, start + len - 1);
      step_to(start + len - 1);
      bus.soft_rst_req = 1'b0;
    end
    step_to(run_edge + 3);

    // Reset in the middle of the release sequence, then at a random point.
    rst_n_sys = 1'b0;
    #1;
    exp_q.delete();
    run_edge = 0;
    release_main();
    mid_reset(30);
    mid_reset(int'($urandom_range(1, 70)));

    // A request after recovery still works.
    step_to(edge_cnt + 5);
    start = edge_cnt + 1;
    bus.soft_rst_req = 1'b1;
    model_req(start, start);
    step_to(start);
    bus.soft_rst_req = 1'b0;
    step_to(run_edge + 3);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d events outstanding, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
